nn_param_regfile: RTL and testbench

- Parametrised successor to the fixed NN register bank: a Wishbone-slave register file holding operands A/B, NUM_PARAMS writable weight/bias slots, a control register and a status register.
- Each slot has a per-slot reset value, and writes honour byte selects.
- Ack is registered, one cycle, and there is a start/done handshake with the NN datapath.
- Sits between the Wishbone bus and the FP neural-network datapath, and feeds it a flat parameter bus.

---
 rtl/nn_param_regfile.sv | 104 ++++++++++
 tb/tb_nn_param_regfile.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_param_regfile.sv
// Wishbone-slave register file for the FP neural-network datapath: operands,
// weight/bias slots, control/status, and a start/done handshake.
module nn_param_regfile #(
    parameter logic [31:0]              BASE_ADDR  = 32'h3000_0000,
    parameter int                       NUM_PARAMS = 9,
    parameter logic [32*NUM_PARAMS-1:0] PARAM_INIT = {NUM_PARAMS{32'h0}},
    parameter logic [31:0]              WIN_BYTES  = 32'h100
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_we_i,
    input  logic [3:0]                 wbs_sel_i,
    input  logic [31:0]                wbs_adr_i,
    input  logic [31:0]                wbs_dat_i,
    output logic                       wbs_ack_o,
    output logic [31:0]                wbs_dat_o,
    output logic [31:0]                opA,
    output logic [31:0]                opB,
    output logic [32*NUM_PARAMS-1:0]   params_o,
    output logic                       start_o,
    input  logic                       nn_busy_i,
    input  logic                       nn_done_i
);

    logic [31:0] offset;
    logic [29:0] word;
    logic [29:0] slot_word;
    logic        hit;
    logic        commit;
    logic        wr;
    logic        lock;
    logic        done;
    logic [31:0] rd_data;
    logic [NUM_PARAMS-1:0][31:0] slot;

    function automatic logic [31:0] merge(input logic [31:0] cur,
                                          input logic [31:0] dat,
                                          input logic [3:0]  sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = sel[b] ? dat[8*b +: 8] : cur[8*b +: 8];
        return r;
    endfunction

    // Unsigned subtract: addresses below the base wrap to a huge offset and miss.
    assign offset    = wbs_adr_i - BASE_ADDR;
    assign word      = offset[31:2];
    assign slot_word = word - 30'd4;
    assign hit       = wbs_cyc_i & wbs_stb_i & (offset < WIN_BYTES);
    assign commit    = hit & ~wbs_ack_o;
    assign wr        = commit & wbs_we_i;
    assign params_o  = slot;

    always_comb begin
        rd_data = 32'h0;
        case (word)
            30'd0:   rd_data = opA;
            30'd1:   rd_data = opB;
            30'd2:   rd_data = {30'b0, lock, 1'b0};
            30'd3:   rd_data = {30'b0, done, nn_busy_i};
            default: begin
                for (int i = 0; i < NUM_PARAMS; i++)
                    if (slot_word == 30'(i)) rd_data = slot[i];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
            start_o   <= 1'b0;
            opA       <= 32'h0;
            opB       <= 32'h0;
            lock      <= 1'b0;
            done      <= 1'b0;
            slot      <= PARAM_INIT;
        end else begin
            wbs_ack_o <= hit & ~wbs_ack_o;
            wbs_dat_o <= commit ? rd_data : 32'h0;
            start_o   <= wr && (word == 30'd2) && wbs_dat_i[0] && wbs_sel_i[0] && !nn_busy_i;

            if (wr && !nn_busy_i && (word == 30'd0))
                opA <= merge(opA, wbs_dat_i, wbs_sel_i);
            if (wr && !nn_busy_i && (word == 30'd1))
                opB <= merge(opB, wbs_dat_i, wbs_sel_i);
            if (wr && (word == 30'd2) && wbs_sel_i[0])
                lock <= wbs_dat_i[1];

            // A completion in the same cycle as the W1C keeps DONE set.
            if (nn_done_i)
                done <= 1'b1;
            else if (wr && (word == 30'd3) && wbs_dat_i[1] && wbs_sel_i[0])
                done <= 1'b0;

            for (int i = 0; i < NUM_PARAMS; i++)
                if (wr && !lock && !nn_busy_i && (word >= 30'd4) && (slot_word == 30'(i)))
                    slot[i] <= merge(slot[i], wbs_dat_i, wbs_sel_i);
        end
    end

endmodule

// File: tb/tb_nn_param_regfile.sv
// Randomized bench for nn_param_regfile against an array-based register model.
module tb_nn_param_regfile;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          NP   = 9;
    localparam int          WIN_WORDS = 64;
    localparam logic [32*NP-1:0] INIT = {32'h1111_0008, 32'h0000_0000, 32'hA5A5_0006,
                                         32'h3F80_0000, 32'hC000_0004, 32'h0000_0000,
                                         32'h0000_0002, 32'h0000_0000, 32'h4080_0000};

    logic              clk = 1'b0;
    logic              rst_l;
    logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i, wbs_dat_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;
    logic [31:0]       opA, opB;
    logic [32*NP-1:0]  params_o;
    logic              start_o;
    logic              nn_busy_i, nn_done_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_opa, m_opb;
    logic        m_lock, m_done;
    logic [31:0] m_slot [NP];

    nn_param_regfile #(
        .BASE_ADDR (BASE),
        .NUM_PARAMS(NP),
        .PARAM_INIT(INIT),
        .WIN_BYTES (32'h100)
    ) dut (
        .clk      (clk),
        .rst_l    (rst_l),
        .wbs_cyc_i(wbs_cyc_i),
        .wbs_stb_i(wbs_stb_i),
        .wbs_we_i (wbs_we_i),
        .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i),
        .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .opA      (opA),
        .opB      (opB),
        .params_o (params_o),
        .start_o  (start_o),
        .nn_busy_i(nn_busy_i),
        .nn_done_i(nn_done_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_opa  = 32'h0;
        m_opb  = 32'h0;
        m_lock = 1'b0;
        m_done = 1'b0;
        for (int i = 0; i < NP; i++) m_slot[i] = INIT[32*i +: 32];
    endtask

    function automatic logic [31:0] bytes_merge(input logic [31:0] cur, input logic [31:0] dat,
                                                input logic [3:0] sel);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int word, input logic busy);
        if (word == 0) return m_opa;
        if (word == 1) return m_opb;
        if (word == 2) return {30'b0, m_lock, 1'b0};
        if (word == 3) return {30'b0, m_done, busy};
        if (word >= 4 && word < 4 + NP) return m_slot[word-4];
        return 32'h0;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_opA"}, opA, m_opa);
        chk({tag, "_opB"}, opB, m_opb);
        for (int i = 0; i < NP; i++)
            chk($sformatf("%s_slot%0d", tag, i), params_o[32*i +: 32], m_slot[i]);
    endtask

    // One bus access; waits at most 4 edges for ack, then idles one cycle.
    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic dp,
                       output logic got_ack, output int lat,
                       output logic [31:0] rd, output logic got_start);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        nn_done_i = dp;
        got_ack = 1'b0; lat = -1; rd = 32'h0; got_start = 1'b0;
        for (int c = 0; c < 4 && !got_ack; c++) begin
            @(posedge clk); #1;
            nn_done_i = 1'b0;
            if (wbs_ack_o) begin
                got_ack = 1'b1; lat = c; rd = wbs_dat_o; got_start = start_o;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(posedge clk); #1;
        chk("idle_ack", 32'(wbs_ack_o), 32'h0);
        chk("idle_start", 32'(start_o), 32'h0);
        chk("idle_dat", wbs_dat_o, 32'h0);
    endtask

    task automatic do_op(input string tag, input logic we, input int word, input logic [31:0] dat,
                         input logic [3:0] sel, input logic busy, input logic dp);
        logic [31:0] adr, exp_rd, rd;
        logic        exp_ack, exp_start, ack, st;
        int          lat;
        adr       = BASE + 32'(word * 4) + 32'($urandom_range(0, 3));
        exp_ack   = (word >= 0) && (word < WIN_WORDS);
        exp_rd    = m_read(word, busy);
        exp_start = exp_ack && we && word == 2 && dat[0] && sel[0] && !busy;
        nn_busy_i = busy;
        bus(we, adr, dat, sel, dp, ack, lat, rd, st);
        chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        if (exp_ack) begin
            chk({tag, "_lat"}, 32'(lat), 32'h0);
            chk({tag, "_rd"}, rd, exp_rd);
            chk({tag, "_start"}, 32'(st), 32'(exp_start));
        end
        if (exp_ack && we) begin
            if (word == 0 && !busy) m_opa = bytes_merge(m_opa, dat, sel);
            if (word == 1 && !busy) m_opb = bytes_merge(m_opb, dat, sel);
            if (word == 2 && sel[0]) m_lock = dat[1];
            if (word >= 4 && word < 4 + NP && !m_lock && !busy)
                m_slot[word-4] = bytes_merge(m_slot[word-4], dat, sel);
        end
        if (dp) m_done = 1'b1;
        else if (exp_ack && we && word == 3 && dat[1] && sel[0]) m_done = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        logic ack_seen [4];
        rst_l = 1'b0;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
        wbs_adr_i = 0; wbs_dat_i = 0; nn_busy_i = 0; nn_done_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 32'(wbs_ack_o), 32'h0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_start", 32'(start_o), 32'h0);
        check_outputs("rst");
        rst_l = 1'b1;
        @(posedge clk); #1;

        do_op("rd_slot0", 1'b0, 4, 32'h0, 4'hF, 1'b0, 1'b0);
        do_op("rd_opa", 1'b0, 0, 32'h0, 4'hF, 1'b0, 1'b0);

        do_op("wr_slot1", 1'b1, 5, 32'hDEAD_BEEF, 4'b0101, 1'b0, 1'b0);
        chk("slot1_const", params_o[63:32], 32'h00AD_00EF);

        do_op("lock_on", 1'b1, 2, 32'h2, 4'hF, 1'b0, 1'b0);
        do_op("wr_locked", 1'b1, 6, 32'h1234, 4'hF, 1'b0, 1'b0);
        chk("slot2_kept", params_o[95:64], INIT[95:64]);
        do_op("lock_off", 1'b1, 2, 32'h0, 4'hF, 1'b0, 1'b0);
        do_op("wr_unlocked", 1'b1, 6, 32'h1234, 4'hF, 1'b0, 1'b0);
        chk("slot2_const", params_o[95:64], 32'h0000_1234);

        do_op("start_idle", 1'b1, 2, 32'h1, 4'hF, 1'b0, 1'b0);
        do_op("start_busy", 1'b1, 2, 32'h1, 4'hF, 1'b1, 1'b0);
        do_op("wr_opa_busy", 1'b1, 0, 32'h5555_AAAA, 4'hF, 1'b1, 1'b0);

        nn_busy_i = 1'b0;
        nn_done_i = 1'b1;
        @(posedge clk); #1;
        nn_done_i = 1'b0;
        m_done = 1'b1;
        do_op("status_done", 1'b0, 3, 32'h0, 4'hF, 1'b0, 1'b0);
        do_op("w1c_vs_set", 1'b1, 3, 32'h2, 4'h1, 1'b0, 1'b1);
        do_op("status_kept", 1'b0, 3, 32'h0, 4'hF, 1'b0, 1'b0);
        do_op("w1c", 1'b1, 3, 32'h2, 4'h1, 1'b0, 1'b0);
        do_op("status_clr", 1'b0, 3, 32'h0, 4'hF, 1'b0, 1'b0);

        do_op("out_win", 1'b1, 128, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0);
        do_op("below_base", 1'b1, -1, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0);

        // Strobe held: ack toggles 1,0,1,0.
        nn_busy_i = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = BASE; wbs_sel_i = 4'hF;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            ack_seen[c] = wbs_ack_o;
            if (wbs_ack_o) chk("held_dat", wbs_dat_o, m_opa);
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        for (int c = 0; c < 4; c++)
            chk($sformatf("held_ack%0d", c), 32'(ack_seen[c]), 32'((c % 2) == 0));
        @(posedge clk); #1;

        for (int n = 0; n < 300; n++) begin
            int          w;
            logic [31:0] d;
            w = $urandom_range(0, 70);
            d = $urandom();
            if ($urandom_range(0, 3) == 0) d[1:0] = 2'($urandom_range(0, 3));
            do_op($sformatf("rnd%0d_w%0d", n, w), 1'($urandom_range(0, 1)), w, d,
                  4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0));
        end

        // Reset during the ack cycle of an OPA write.
        nn_busy_i = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = BASE; wbs_dat_i = 32'hCAFE_F00D; wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        chk("rstmid_ack_before", 32'(wbs_ack_o), 32'h1);
        rst_l = 1'b0;
        #1;
        chk("rstmid_ack", 32'(wbs_ack_o), 32'h0);
        chk("rstmid_opa", opA, 32'h0);
        chk("rstmid_start", 32'(start_o), 32'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_l = 1'b1;
        @(posedge clk); #1;
        check_outputs("after_rst");
        do_op("post_rst_slot0", 1'b0, 4, 32'h0, 4'hF, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
